// File: rtl/iccm_arb_pkg.sv
// Shared types for the ICCM port arbiter.
// Struct field widths match the arbiter's default parameters.
package iccm_arb_pkg;

  localparam int StarveCntW = 4;
  localparam int SramAddrW  = 11;
  localparam int SramDataW  = 32;
  localparam int SramMaskW  = SramDataW / 8;

  typedef enum logic {
    OwnerA = 1'b0,
    OwnerB = 1'b1
  } owner_e;

  typedef struct packed {
    logic                 we;
    logic [SramAddrW-1:0] addr;
    logic [SramDataW-1:0] wdata;
    logic [SramMaskW-1:0] wmask;
  } sram_req_t;

endpackage

// File: rtl/iccm_arb_starve_cnt.sv
// Saturating count of consecutive cycles port A was denied.
// Clear has priority over hold; the count stops at MaxWait.
module iccm_arb_starve_cnt
  import iccm_arb_pkg::*;
#(
  parameter int MaxWait = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic hold_i,
  output logic at_max_o
);

  localparam logic [StarveCntW-1:0] CntMax = StarveCntW'(MaxWait);

  logic [StarveCntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (!hold_i && cnt_q != CntMax) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_max_o = (cnt_q == CntMax);

endmodule

// File: rtl/iccm_port_arbiter.sv
// Two-port arbiter in front of the single-port ICCM SRAM macro.
// Port B is the boot loader; port A is the fetch/debug adapter.
module iccm_port_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int AddrWidth = 11,
  parameter int DataWidth = 32,
  parameter int MaxWait   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   lock_i,
  input  logic                   a_req_i,
  input  logic                   a_we_i,
  input  logic [AddrWidth-1:0]   a_addr_i,
  input  logic [DataWidth-1:0]   a_wdata_i,
  input  logic [DataWidth/8-1:0] a_wmask_i,
  output logic                   a_gnt_o,
  output logic                   a_rvalid_o,
  output logic [DataWidth-1:0]   a_rdata_o,
  input  logic                   b_req_i,
  input  logic                   b_we_i,
  input  logic [AddrWidth-1:0]   b_addr_i,
  input  logic [DataWidth-1:0]   b_wdata_i,
  input  logic [DataWidth/8-1:0] b_wmask_i,
  output logic                   b_gnt_o,
  output logic                   b_rvalid_o,
  output logic [DataWidth-1:0]   b_rdata_o,
  output logic                   sram_csb_o,
  output logic                   sram_web_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  output logic [DataWidth/8-1:0] sram_wmask_o,
  input  logic [DataWidth-1:0]   sram_rdata_i
);

  localparam int MaskW = DataWidth / 8;

  logic      at_max;
  logic      a_gnt;
  logic      b_gnt;
  logic      rvalid_q;
  owner_e    owner_q;
  sram_req_t a_req;
  sram_req_t b_req;
  sram_req_t sel;

  assign a_req = '{we:    a_we_i,
                   addr:  SramAddrW'(a_addr_i),
                   wdata: SramDataW'(a_wdata_i),
                   wmask: SramMaskW'(a_wmask_i)};
  assign b_req = '{we:    b_we_i,
                   addr:  SramAddrW'(b_addr_i),
                   wdata: SramDataW'(b_wdata_i),
                   wmask: SramMaskW'(b_wmask_i)};

  // Grants are gated by reset so outputs go idle asynchronously.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_ni) begin
      if (lock_i) begin
        b_gnt = b_req_i;
      end else if (at_max && a_req_i) begin
        a_gnt = 1'b1;
      end else if (b_req_i) begin
        b_gnt = 1'b1;
      end else if (a_req_i) begin
        a_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    sel = '0;
    if (a_gnt) begin
      sel = a_req;
    end else if (b_gnt) begin
      sel = b_req;
    end
  end

  iccm_arb_starve_cnt #(
    .MaxWait (MaxWait)
  ) u_starve (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (lock_i | a_gnt | !a_req_i),
    .hold_i   (1'b0),
    .at_max_o (at_max)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      owner_q  <= OwnerA;
    end else begin
      rvalid_q <= (a_gnt | b_gnt) & !sel.we;
      if (a_gnt | b_gnt) begin
        owner_q <= b_gnt ? OwnerB : OwnerA;
      end
    end
  end

  assign a_gnt_o      = a_gnt;
  assign b_gnt_o      = b_gnt;
  assign sram_csb_o   = !(a_gnt | b_gnt);
  assign sram_web_o   = !((a_gnt | b_gnt) & sel.we);
  assign sram_addr_o  = AddrWidth'(sel.addr);
  assign sram_wdata_o = DataWidth'(sel.wdata);
  assign sram_wmask_o = MaskW'(sel.wmask);

  assign a_rvalid_o = rvalid_q && (owner_q == OwnerA);
  assign b_rvalid_o = rvalid_q && (owner_q == OwnerB);
  assign a_rdata_o  = sram_rdata_i;
  assign b_rdata_o  = sram_rdata_i;

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed bench for iccm_port_arbiter with a behavioural SRAM.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_iccm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        lock = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [10:0] a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic [3:0]  a_wmask = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [10:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic [3:0]  b_wmask = '0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        csb, web;
  logic [10:0] s_addr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wmask;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  iccm_port_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .lock_i(lock),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_wmask_i(a_wmask),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_wmask_i(b_wmask),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .sram_csb_o(csb), .sram_web_o(web), .sram_addr_o(s_addr),
    .sram_wdata_o(s_wdata), .sram_wmask_o(s_wmask),
    .sram_rdata_i(s_rdata)
  );

  always @(posedge clk) begin
    if (!csb) begin
      if (!web) begin
        for (int i = 0; i < 4; i++)
          if (s_wmask[i]) mem[s_addr][i*8 +: 8] <= s_wdata[i*8 +: 8];
      end else begin
        s_rdata <= mem[s_addr];
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    a_req = 1'b0; b_req = 1'b0; lock = 1'b0;
    a_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle();
    #1;
    checks++;
    if ({csb, web, a_gnt, b_gnt, a_rvalid, b_rvalid} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_hold ctl=%b want 110000",
               {csb, web, a_gnt, b_gnt, a_rvalid, b_rvalid});
    end
    checks++;
    if ({s_addr, s_wdata, s_wmask} !== '0) begin
      failures++;
      $display("FAIL reset_bus addr=%h wdata=%h mask=%h want 0",
               s_addr, s_wdata, s_wmask);
    end
    step();
    rst_ni = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({csb, web, a_gnt, b_gnt, a_rvalid, b_rvalid} !== 6'b110000) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d ctl=%b want 110000", c,
                 {csb, web, a_gnt, b_gnt, a_rvalid, b_rvalid});
      end
      step();
    end
  endtask

  task automatic test_write_read();
    b_req = 1'b1; b_we = 1'b1; b_addr = 11'h010;
    b_wdata = 32'hDEADBEEF; b_wmask = 4'hF;
    #1;
    checks++;
    if ({b_gnt, a_gnt, csb, web} !== 4'b1000) begin
      failures++;
      $display("FAIL b_write_gnt got=%b want 1000", {b_gnt, a_gnt, csb, web});
    end
    checks++;
    if (s_addr !== 11'h010 || s_wdata !== 32'hDEADBEEF || s_wmask !== 4'hF) begin
      failures++;
      $display("FAIL b_write_bus addr=%h data=%h mask=%h", s_addr, s_wdata, s_wmask);
    end
    step();
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h010;
    #1;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL write_no_rvalid got=%b want 00", {a_rvalid, b_rvalid});
    end
    checks++;
    if ({a_gnt, b_gnt, csb, web, s_addr} !== {4'b1001, 11'h010}) begin
      failures++;
      $display("FAIL a_read_gnt got=%b addr=%h want 1001/010",
               {a_gnt, b_gnt, csb, web}, s_addr);
    end
    step();
    a_req = 1'b0;
    #1;
    checks++;
    if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL a_read_ret rv=%b/%b data=%h want 1/0 deadbeef",
               a_rvalid, b_rvalid, a_rdata);
    end
    step();
    #1;
    checks++;
    if (a_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL a_read_once rv=%b want 0", a_rvalid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'h010;
    a_wdata = 32'h12345678; a_wmask = 4'h3;
    #1;
    checks++;
    if ({a_gnt, web, s_wmask} !== 6'b100011) begin
      failures++;
      $display("FAIL a_partial_write got=%b want 100011", {a_gnt, web, s_wmask});
    end
    step();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 11'h010;
    #1;
    checks++;
    if ({b_gnt, csb, web} !== 3'b101) begin
      failures++;
      $display("FAIL b_read_gnt got=%b want 101", {b_gnt, csb, web});
    end
    step();
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h010;
    b_req = 1'b0;
    #1;
    checks++;
    if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0 || b_rdata !== 32'hDEAD5678) begin
      failures++;
      $display("FAIL b_read_ret rv=%b/%b data=%h want 1/0 dead5678",
               b_rvalid, a_rvalid, b_rdata);
    end
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL b2b_a_gnt got=%b want 1", a_gnt);
    end
    step();
    a_req = 1'b0;
    #1;
    checks++;
    if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 || a_rdata !== 32'hDEAD5678) begin
      failures++;
      $display("FAIL b2b_a_ret rv=%b/%b data=%h want 1/0 dead5678",
               a_rvalid, b_rvalid, a_rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    logic exp_a;
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'h020; a_wmask = 4'h0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 11'h030; b_wmask = 4'h0;
    for (int c = 0; c < 15; c++) begin
      exp_a = (c % 5 == 4);
      #1;
      checks++;
      if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
        failures++;
        $display("FAIL starve cyc=%0d a_gnt=%b b_gnt=%b want %b/%b",
                 c, a_gnt, b_gnt, exp_a, !exp_a);
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_lock();
    lock = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h010;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if ({a_gnt, b_gnt, csb} !== 3'b001) begin
        failures++;
        $display("FAIL lock_block cyc=%0d got=%b want 001", c, {a_gnt, b_gnt, csb});
      end
      step();
    end
    lock = 1'b0;
    #1;
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL lock_release a_gnt=%b want 1", a_gnt);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_lock_mid_read();
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h010;
    #1;
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL lmr_gnt a_gnt=%b want 1", a_gnt);
    end
    step();
    lock = 1'b1;
    #1;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD5678 || a_gnt !== 1'b0) begin
      failures++;
      $display("FAIL lmr_ret rv=%b data=%h gnt=%b want 1 dead5678 0",
               a_rvalid, a_rdata, a_gnt);
    end
    step();
    #1;
    checks++;
    if (a_rvalid !== 1'b0 || a_gnt !== 1'b0) begin
      failures++;
      $display("FAIL lmr_after rv=%b gnt=%b want 0 0", a_rvalid, a_gnt);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_reset_mid_read();
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h010;
    #1;
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rmr_gnt a_gnt=%b want 1", a_gnt);
    end
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({a_rvalid, b_rvalid, a_gnt, b_gnt, csb, web} !== 6'b000011 ||
        {s_addr, s_wdata, s_wmask} !== '0) begin
      failures++;
      $display("FAIL rmr_async ctl=%b addr=%h want 000011 0",
               {a_rvalid, b_rvalid, a_gnt, b_gnt, csb, web}, s_addr);
    end
    step();
    a_req = 1'b0;
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (a_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL rmr_no_rvalid cyc=%0d rv=%b want 0", c, a_rvalid);
      end
      step();
    end
  endtask

  initial begin
    step();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_starvation();
    test_lock();
    test_lock_mid_read();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
